// File: rtl/jtframe_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_video_pkg
// Brief    : Shared video constants: scanline dimming mode encodings.
// Revision : 1.0 - initial release
// ============================================================================
package jtframe_video_pkg;

  typedef logic [1:0] scan_mode_t;

  localparam scan_mode_t OFF   = 2'b00;
  localparam scan_mode_t DIM25 = 2'b01;
  localparam scan_mode_t DIM50 = 2'b10;
  localparam scan_mode_t DIM75 = 2'b11;

endpackage
`default_nettype wire

// File: rtl/jtframe_scanline_dim.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_scanline_dim
// Brief    : Combinational dimming of one colour channel on dimmed lines.
// Revision : 1.0 - initial release
// ============================================================================
module jtframe_scanline_dim
  import jtframe_video_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [1:0]    mode,
  input  logic          dim,
  input  logic [CW-1:0] c_in,
  output logic [CW-1:0] c_out
);

  // Every result is no larger than c_in, so CW bits never overflow
  always_comb begin
    c_out = c_in;
    if (dim) begin
      case (mode)
        DIM25:   c_out = c_in - (c_in >> 2);
        DIM50:   c_out = c_in >> 1;
        DIM75:   c_out = c_in >> 2;
        default: c_out = c_in;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/jtframe_scanlines.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_scanlines
// Brief    : Two-stage scanline dimmer for scan-doubled video, odd lines dimmed.
// Config   : JTFRAME_SCANLINE_BLEND_EN adds horizontal averaging with the
//            previous pixel of the same line before dimming.
// Revision : 1.0 - initial release
// ============================================================================
module jtframe_scanlines #(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl2_cen,
  input  logic [1:0]    scan_mode,
  input  logic [DW-1:0] pxl_in,
  input  logic          HS,
  input  logic          VS,
  output logic [DW-1:0] pxl_out,
  output logic          HS_out,
  output logic          VS_out,
  output logic          odd_line
);
  import jtframe_video_pkg::*;

  localparam int CW = DW / 3;

  if (DW % 3 != 0) begin : g_dw_check
    $error("jtframe_scanlines: DW must be a multiple of 3");
  end

  // r_hs_d/r_vs_d serve both as edge-detect history and as stage-1 syncs
  logic          r_hs_d;
  logic          r_vs_d;
  logic          r_par;
  logic [1:0]    r_mode;
  logic [DW-1:0] r_s1_pxl;

  logic          w_hs_rise;
  logic          w_vs_rise;
  logic          w_par_next;
  logic [DW-1:0] w_src;
  logic [DW-1:0] w_dim;

  assign w_hs_rise  = HS & ~r_hs_d;
  assign w_vs_rise  = VS & ~r_vs_d;
  assign w_par_next = w_vs_rise ? 1'b0 : (w_hs_rise ? ~r_par : r_par);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs_d   <= 1'b0;
      r_vs_d   <= 1'b0;
      r_par    <= 1'b0;
      r_mode   <= OFF;
      r_s1_pxl <= '0;
      pxl_out  <= '0;
      HS_out   <= 1'b0;
      VS_out   <= 1'b0;
      odd_line <= 1'b0;
    end else if (pxl2_cen) begin
      r_hs_d   <= HS;
      r_vs_d   <= VS;
      r_par    <= w_par_next;
      r_s1_pxl <= pxl_in;
      if (w_vs_rise) r_mode <= scan_mode;
      pxl_out  <= w_dim;
      HS_out   <= r_hs_d;
      VS_out   <= r_vs_d;
      odd_line <= r_par;
    end
  end

`ifdef JTFRAME_SCANLINE_BLEND_EN
  logic [DW-1:0] r_prev;
  logic          r_first;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= '0;
      r_first <= 1'b0;
    end else if (pxl2_cen) begin
      r_prev  <= r_s1_pxl;
      r_first <= w_hs_rise;
    end
  end

  // The pixel that arrived with the HS edge pairs with itself, not the last line
  for (genvar i = 0; i < 3; i++) begin : g_blend
    logic [CW-1:0] w_other;
    logic [CW:0]   w_sum;
    logic          w_unused_lsb;

    assign w_other = r_first ? r_s1_pxl[i*CW +: CW] : r_prev[i*CW +: CW];
    assign w_sum   = {1'b0, r_s1_pxl[i*CW +: CW]} + {1'b0, w_other}
                   + {{CW{1'b0}}, 1'b1};
    assign {w_src[i*CW +: CW], w_unused_lsb} = w_sum;
  end
`else
  assign w_src = r_s1_pxl;
`endif

  for (genvar i = 0; i < 3; i++) begin : g_ch
    jtframe_scanline_dim #(
      .CW (CW)
    ) u_dim (
      .mode  (r_mode),
      .dim   (r_par),
      .c_in  (w_src[i*CW +: CW]),
      .c_out (w_dim[i*CW +: CW])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_scanlines.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtframe_scanlines
// Brief    : Scoreboard bench for jtframe_scanlines with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtframe_scanlines;

  typedef struct packed {
    logic [11:0] pxl;
    logic        hs;
    logic        vs;
    logic        odd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pxl2_cen = 1'b0;
  logic [1:0]  scan_mode = 2'b00;
  logic [11:0] pxl_in = '0;
  logic        HS = 1'b0;
  logic        VS = 1'b0;
  logic [11:0] pxl_out;
  logic        HS_out;
  logic        VS_out;
  logic        odd_line;

  int n_checks = 0;
  int n_pass   = 0;
  int cen_pct  = 100;

  exp_t q[$];
  exp_t last_exp = '0;

  // Reference model state
  logic        m_hs, m_vs, m_par;
  logic [1:0]  m_mode;
  logic [11:0] m_prev;

  jtframe_scanlines #(.DW(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .pxl2_cen  (pxl2_cen),
    .scan_mode (scan_mode),
    .pxl_in    (pxl_in),
    .HS        (HS),
    .VS        (VS),
    .pxl_out   (pxl_out),
    .HS_out    (HS_out),
    .VS_out    (VS_out),
    .odd_line  (odd_line)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] dim_ref(logic [11:0] x, logic [1:0] m, logic par);
    logic [11:0] r;
    r = x;
    if (par) begin
      for (int c = 0; c < 3; c++) begin
        int v;
        v = int'(x[c*4 +: 4]);
        if (m == 2'd1)      v = v - v / 4;
        else if (m == 2'd2) v = v / 2;
        else if (m == 2'd3) v = v / 4;
        r[c*4 +: 4] = 4'(v);
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input exp_t e);
    n_checks++;
    if (pxl_out === e.pxl && HS_out === e.hs && VS_out === e.vs && odd_line === e.odd)
      n_pass++;
    else
      $display("FAIL %s @%0t: got pxl=%h hs=%b vs=%b odd=%b, expected pxl=%h hs=%b vs=%b odd=%b",
               name, $time, pxl_out, HS_out, VS_out, odd_line, e.pxl, e.hs, e.vs, e.odd);
  endtask

  // Monitor: every cen edge presents one output word
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        last_exp = '0;
        check("reset", last_exp);
      end else if (pxl2_cen) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL underflow @%0t: output with no expected entry, got pxl=%h expected none",
                   $time, pxl_out);
        end else begin
          last_exp = q.pop_front();
          check("pixel", last_exp);
        end
      end else begin
        check("hold", last_exp);
      end
    end
  end

  task automatic step(input logic cen, input logic [11:0] p, input logic h,
                      input logic v, input logic [1:0] m);
    exp_t e;
    logic hr, vr;
    logic [11:0] src;
    @(negedge clk);
    rst = 1'b0; pxl2_cen = cen; pxl_in = p; HS = h; VS = v; scan_mode = m;
    if (cen) begin
      hr = h & ~m_hs;
      vr = v & ~m_vs;
      if (vr) begin
        m_par  = 1'b0;
        m_mode = m;
      end else if (hr) begin
        m_par = ~m_par;
      end
      src = p;
`ifdef JTFRAME_SCANLINE_BLEND_EN
      for (int c = 0; c < 3; c++) begin
        int cur, oth;
        cur = int'(p[c*4 +: 4]);
        oth = hr ? cur : int'(m_prev[c*4 +: 4]);
        src[c*4 +: 4] = 4'((cur + oth + 1) / 2);
      end
`endif
      m_prev = p;
      m_hs = h;
      m_vs = v;
      e.pxl = dim_ref(src, m_mode, m_par);
      e.hs  = h;
      e.vs  = v;
      e.odd = m_par;
      q.push_back(e);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1;
      pxl2_cen = 1'($urandom);
      HS = 1'($urandom);
      VS = 1'($urandom);
      pxl_in = 12'($urandom);
    end
    q.delete();
    m_hs = 1'b0; m_vs = 1'b0; m_par = 1'b0; m_mode = 2'b00; m_prev = '0;
    q.push_back('0);   // first post-reset output drains the zeroed stage 1
  endtask

  // kind: 0 constant base, 1 random, 2 alternating ~base/base
  task automatic line(input int len, input logic [11:0] base, input int kind,
                      input logic [1:0] m, input bit vs);
    for (int i = 0; i < len; i++) begin
      logic [11:0] p;
      logic c;
      if (kind == 0)      p = base;
      else if (kind == 1) p = 12'($urandom);
      else                p = (i % 2 == 1) ? base : ~base;
      c = ($urandom_range(99) < cen_pct);
      step(c, p, i < 2, vs && (i < 2), m);
    end
  endtask

  initial begin
    do_reset(3);

    // 50% on constant white
    line(8, 12'hFFF, 0, 2'b10, 1'b1);
    for (int l = 0; l < 4; l++) line(8, 12'hFFF, 0, 2'b10, 1'b0);

    // 25% and 75% on 12'h840
    line(6, 12'h840, 0, 2'b01, 1'b1);
    for (int l = 0; l < 3; l++) line(6, 12'h840, 0, 2'b01, 1'b0);
    line(6, 12'h840, 0, 2'b11, 1'b1);
    for (int l = 0; l < 3; l++) line(6, 12'h840, 0, 2'b11, 1'b0);

    // mid-frame mode change is ignored until the next VS
    line(6, 12'hFFF, 0, 2'b10, 1'b1);
    for (int l = 0; l < 3; l++) line(6, 12'hFFF, 0, 2'b11, 1'b0);
    line(6, 12'hFFF, 0, 2'b11, 1'b1);
    for (int l = 0; l < 3; l++) line(6, 12'hFFF, 0, 2'b11, 1'b0);

    // cen held low: outputs frozen while inputs wiggle
    for (int i = 0; i < 5; i++) step(1'b0, 12'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
    line(6, 12'hFFF, 0, 2'b11, 1'b0);

    // reset mid-line, then parity restarts
    line(3, 12'hABC, 1, 2'b10, 1'b1);
    do_reset(1);
    for (int l = 0; l < 3; l++) line(6, 12'hFFF, 0, 2'b10, 1'b0);

    // blend pattern: 000 then FFF in mode 00
    line(6, 12'hFFF, 2, 2'b00, 1'b1);
    line(6, 12'hFFF, 2, 2'b00, 1'b0);

    // randomized frames with gapped enables and occasional resets
    for (int f = 0; f < 30; f++) begin
      cen_pct = $urandom_range(50, 100);
      line($urandom_range(4, 16), '0, 1, 2'($urandom), 1'b1);
      for (int l = 0; l < int'($urandom_range(2, 5)); l++) begin
        if ($urandom_range(19) == 0) do_reset($urandom_range(1, 3));
        line($urandom_range(3, 16), 12'($urandom), int'($urandom_range(0, 2)),
             2'($urandom), 1'b0);
      end
    end

    cen_pct = 100;
    line(4, 12'h123, 1, 2'b00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
